// File: rtl/regfile_debug_port.sv
// Debugger access to the RV32I integer register file.
// Halts the core, performs one read or write, returns the result.
module regfile_debug_port #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int HALT_TIMEOUT   = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [XLEN-1:0]           req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [XLEN-1:0]           rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      halt_req_o,
  input  logic                      halt_ack_i,
  output logic                      rf_write_enable_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_address_o,
  output logic [XLEN-1:0]           rf_write_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_address_o,
  input  logic [XLEN-1:0]           rf_read_data_i
);

  localparam int CW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(HALT_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic halt_q, halt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [REG_ADDR_WIDTH-1:0] rf_raddr_q, rf_raddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  // State, request capture and every registered output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      halt_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_raddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      halt_q      <= halt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_raddr_q  <= rf_raddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  // Next state; ack is checked before the timeout so it wins a tie
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_HALT;
          cnt_d   = '0;
          wr_d    = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
        end
      end
      S_HALT: begin
        if (halt_ack_i) begin
          state_d = S_ACCESS;
        end else if (cnt_q == TO_MAX) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values, derived from the state being entered
  always_comb begin
    halt_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    rf_we_d     = 1'b0;
    rf_waddr_d  = '0;
    rf_raddr_d  = '0;
    rf_wdata_d  = '0;
    if (state_d == S_ACCESS) begin
      rf_waddr_d = addr_q;
      rf_raddr_d = addr_q;
      if (wr_q) begin
        rf_wdata_d = wdata_q;
        rf_we_d    = (addr_q != '0);
      end
    end
    unique case (state_q)
      S_HALT: rsp_err_d = (state_d == S_RESP);
      S_ACCESS: begin
        if (!wr_q && addr_q != '0) rsp_rdata_d = rf_read_data_i;
      end
      S_RESP: begin
        if (state_d == S_RESP) begin
          rsp_err_d   = rsp_err_q;
          rsp_rdata_d = rsp_rdata_q;
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o        = (state_q == S_IDLE);
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_err_o          = rsp_err_q;
  assign rsp_rdata_o        = rsp_rdata_q;
  assign halt_req_o         = halt_q;
  assign rf_write_enable_o  = rf_we_q;
  assign rf_write_address_o = rf_waddr_q;
  assign rf_write_data_o    = rf_wdata_q;
  assign rf_read_address_o  = rf_raddr_q;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Directed bench for regfile_debug_port.
// Register-file model writes on negedge and reads combinationally.
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        halt_req_o, halt_ack_i;
  logic        rf_write_enable_o;
  logic [4:0]  rf_write_address_o, rf_read_address_o;
  logic [31:0] rf_write_data_o, rf_read_data_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_debug_port dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_write_i        (req_write_i),
    .req_addr_i         (req_addr_i),
    .req_wdata_i        (req_wdata_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_rdata_o        (rsp_rdata_o),
    .rsp_err_o          (rsp_err_o),
    .halt_req_o         (halt_req_o),
    .halt_ack_i         (halt_ack_i),
    .rf_write_enable_o  (rf_write_enable_o),
    .rf_write_address_o (rf_write_address_o),
    .rf_write_data_o    (rf_write_data_o),
    .rf_read_address_o  (rf_read_address_o),
    .rf_read_data_i     (rf_read_data_i)
  );

  // x0 holds garbage in the model so a forced-zero read is observable
  logic [31:0] rf_m [32];
  logic        tb_load;

  always @(negedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++)
        rf_m[i] <= (i == 0) ? 32'hFFFF_FFFF :
                   (i == 10) ? 32'h0000_00A5 : 32'h0;
    end else if (rf_write_enable_o) begin
      rf_m[rf_write_address_o] <= rf_write_data_o;
    end
  end

  assign rf_read_data_i = rf_m[rf_read_address_o];

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          ack_at;
    int          rdy_wait;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int we_cnt;
    bit seen;
    chk("req_ready_idle", 32'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_write_i = v.wr;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    halt_ack_i  = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("halt_req_on", 32'(halt_req_o), 1);
    chk("req_ready_busy", 32'(req_ready_o), 0);
    lat = 0;
    we_cnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (v.ack_at > 0 && k >= v.ack_at) halt_ack_i = 1'b1;
      @(posedge clk); #1;
      if (rf_write_enable_o) begin
        we_cnt++;
        chk("rf_waddr", 32'(rf_write_address_o), 32'(v.addr));
        chk("rf_wdata", rf_write_data_o, v.wdata);
      end
      if (k == v.ack_at)
        chk("rf_raddr", 32'(rf_read_address_o), 32'(v.addr));
      if (rsp_valid_o) begin
        seen = 1'b1;
        lat = k;
      end
    end
    chk("rsp_seen", 32'(seen), 1);
    chk("latency", lat, v.exp_lat);
    chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
    chk("we_pulses", we_cnt, v.exp_we);
    chk("rf_idle_addr", 32'(rf_read_address_o), 0);
    chk("rf_idle_wdata", rf_write_data_o, 0);
    for (int w = 0; w < v.rdy_wait; w++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid_o), 1);
      chk("hold_rdata", rsp_rdata_o, v.exp_rdata);
      chk("hold_halt", 32'(halt_req_o), 1);
      chk("hold_ready", 32'(req_ready_o), 0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    halt_ack_i = 1'b0;
    chk("post_halt", 32'(halt_req_o), 0);
    chk("post_valid", 32'(rsp_valid_o), 0);
    chk("post_err", 32'(rsp_err_o), 0);
    chk("post_ready", 32'(req_ready_o), 1);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{1, 5'd5, 32'hDEAD_BEEF, 2, 0, 32'h0, 0, 3, 1};
    vecs[1] = '{0, 5'd5, 32'h0, 1, 0, 32'hDEAD_BEEF, 0, 2, 0};
    vecs[2] = '{1, 5'd0, 32'h1234_5678, 2, 0, 32'h0, 0, 3, 0};
    vecs[3] = '{0, 5'd0, 32'h0, 1, 0, 32'h0, 0, 2, 0};
    vecs[4] = '{1, 5'd7, 32'hCAFE_0007, -1, 0, 32'h0, 1, 16, 0};
    vecs[5] = '{0, 5'd10, 32'h0, 3, 4, 32'h0000_00A5, 0, 4, 0};
    vecs[6] = '{1, 5'd3, 32'h0BAD_F00D, 16, 0, 32'h0, 0, 17, 1};
    vecs[7] = '{0, 5'd3, 32'h0, 1, 0, 32'h0BAD_F00D, 0, 2, 0};
    vecs[8] = '{0, 5'd7, 32'h0, 2, 1, 32'h0, 0, 3, 0};

    rst_n = 1'b0;
    tb_load = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    halt_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tb_load = 1'b0;
    chk("rst_halt", 32'(halt_req_o), 0);
    chk("rst_valid", 32'(rsp_valid_o), 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_err", 32'(rsp_err_o), 0);
    chk("rst_we", 32'(rf_write_enable_o), 0);
    chk("rst_waddr", 32'(rf_write_address_o), 0);
    chk("rst_ready", 32'(req_ready_o), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset while waiting for ack in HALT
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i = 5'd9;
    req_wdata_i = 32'h1111_1111;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("halt_before_rst", 32'(halt_req_o), 1);
    rst_n = 1'b0;
    #1;
    chk("rstA_halt_async", 32'(halt_req_o), 0);
    chk("rstA_valid", 32'(rsp_valid_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstA_ready", 32'(req_ready_o), 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("rstA_no_rsp", 32'(rsp_valid_o), 0);
    end

    // Reset in the middle of the ACCESS cycle of a write
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i = 5'd9;
    req_wdata_i = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    halt_ack_i = 1'b1;
    @(posedge clk); #1;
    chk("rstB_we_before", 32'(rf_write_enable_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstB_we_async", 32'(rf_write_enable_o), 0);
    chk("rstB_halt_async", 32'(halt_req_o), 0);
    halt_ack_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstB_ready", 32'(req_ready_o), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("rstB_no_rsp", 32'(rsp_valid_o), 0);
    end

    // The aborted write must not have reached the register file
    rv = '{0, 5'd9, 32'h0, 1, 0, 32'h0, 0, 2, 0};
    run_vec(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_debug_port.md
# regfile_debug_port

Debug access unit that reads and writes the integer register file of the single-cycle RV32I core on behalf of an external debugger. It accepts one request at a time over a valid/ready channel, halts the core, waits for the core's acknowledge, and performs one access on the register file's read/write port. It then returns the result over a second valid/ready channel and releases the halt. It sits between the debug transport and the register file. Its register-file outputs are muxed over the core's own register-file port while `halt_req_o` is high.

## Interface
- `XLEN`, 32, data width of the register file
- `REG_ADDR_WIDTH`, 5, register address width
- `HALT_TIMEOUT`, 15, maximum cycles to wait for `halt_ack_i` (must be at least 1)

Ports:
- `clk_i`  in  1  clock; the block uses the posedge only
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  request ready
- `req_write_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  REG_ADDR_WIDTH  target register
- `req_wdata_i`  in  XLEN  write data
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  response ready
- `rsp_rdata_o`  out  XLEN  read data; 0 for writes and errors
- `rsp_err_o`  out  1  halt timeout; no access was performed
- `halt_req_o`  out  1  freeze core PC and core register-file writes
- `halt_ack_i`  in  1  core is quiesced
- `rf_write_enable_o`  out  1  register-file write enable
- `rf_write_address_o`  out  REG_ADDR_WIDTH  register-file write address
- `rf_write_data_o`  out  XLEN  register-file write data
- `rf_read_address_o`  out  REG_ADDR_WIDTH  register-file read address
- `rf_read_data_i`  in  XLEN  register-file combinational read data

## Operation
- FSM states: IDLE, HALT, ACCESS, RESP. All outputs are registered, except `req_ready_o`, which is `state==IDLE`.
- IDLE
  - On `req_valid_i && req_ready_o`, capture write flag, address and wdata, clear the timeout counter, and go to HALT.
- HALT
  - `halt_req_o`=1.
  - If `halt_ack_i`=1, go to ACCESS.
  - Otherwise increment the counter. When the counter reaches `HALT_TIMEOUT`, go to RESP with `rsp_err_o`=1 and `rsp_rdata_o`=0.
  - Counter width is clog2(HALT_TIMEOUT+1) and it saturates; it never wraps.
- ACCESS, exactly one cycle
  - `rf_read_address_o` and `rf_write_address_o` = captured address.
  - Write request:
    - `rf_write_data_o` = wdata.
    - `rf_write_enable_o`=1 for the whole cycle, so it covers the register file's negedge write.
    - Address 0: `rf_write_enable_o` stays 0, the response is a normal completion with err=0.
  - Read request: `rf_read_data_i` is captured at the end of the cycle. Address 0 forces 0.
  - Go to RESP.
- RESP
  - `rsp_valid_o`=1 and holds until `rsp_ready_i`.
  - `rsp_rdata_o` and `rsp_err_o` are stable while `rsp_valid_o`=1.
  - On the handshake, return to IDLE. `halt_req_o`, `rsp_valid_o` and `rsp_err_o` drop in the same edge.
- `halt_req_o` is 1 in HALT, ACCESS and RESP, and 0 in IDLE.
- The `rf_*` address and data outputs are driven 0 outside ACCESS. `rf_write_enable_o` is 1 only in ACCESS on a write to a nonzero address.
- Requests arriving while not in IDLE are not accepted. The requester holds `req_valid_i` and payload stable until ready.
- `halt_ack_i` dropping during ACCESS or RESP is ignored.

## Timing
- Reset (`rst_ni`=0, asynchronous): state=IDLE, counter=0.
  - Every registered output is 0: `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, `halt_req_o` and all `rf_*` outputs.
  - Reset mid-operation aborts without a response. `halt_req_o` and `rf_write_enable_o` fall immediately, without waiting for a clock edge.
- Request accepted at edge 0:
  - `halt_req_o`=1 after edge 0.
  - If `halt_ack_i` is sampled 1 at edge k (k≥1), ACCESS runs between edges k and k+1.
  - `rsp_valid_o` rises after edge k+1.
  - Minimum request-to-response latency is 2 cycles after acceptance, with ack already high.
- Timeout path: with no ack, `rsp_valid_o` (err=1) rises after edge HALT_TIMEOUT+1 counted from acceptance. No `rf_write_enable_o` pulse occurs.
- Throughput: a new request can be accepted at the earliest on the edge after the response handshake, since `req_ready_o` rises in IDLE.
- Simultaneous `halt_ack_i` and timeout at the same edge: ack wins and the access is performed.

## Test plan
- Write x5 = 0xDEADBEEF, ack one cycle after `halt_req_o`:
  - `rf_write_enable_o` pulses for exactly one cycle with addr 5 and data 0xDEADBEEF.
  - Response err=0 follows.
  - A subsequent read of x5 returns 0xDEADBEEF.
- Write x0 = 0x12345678:
  - No `rf_write_enable_o` pulse.
  - Response err=0, rdata=0.
  - A read of x0 returns 0.
- `halt_ack_i` held 0, `HALT_TIMEOUT`=15:
  - `rsp_valid_o` rises 16 cycles after acceptance with err=1, rdata=0.
  - No rf activity.
  - `halt_req_o` drops on the handshake.
- Read x10 (register-file model holds 0x0000_00A5) with `rsp_ready_i` held 0 for 4 cycles:
  - `rsp_valid_o`, rdata=0xA5 and `halt_req_o` stay stable throughout.
  - `req_ready_o`=0 throughout.
  - A second request is accepted only after the handshake.
- Assert `rst_ni`=0 mid-HALT and separately mid-ACCESS of a write:
  - `halt_req_o` and `rf_write_enable_o` go to 0 asynchronously.
  - No response is issued.
  - After reset, `req_ready_o`=1.
- Ack and timeout coinciding at cycle 15: the access is performed and err=0.
